uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo.sv | 150 +++++++++++++++
 tb/tb_uart_tx_fifo.sv | 135 +++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a wrap-around pointer FIFO.
// Frames are back-to-back while words are queued; the line is driven from a flop.
module uart_tx_fifo #(
    parameter int CLK_PER_BIT = 5208,
    parameter int DATA_BITS   = 8,
    parameter int PARITY      = 0,
    parameter int STOP_BITS   = 1,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                          sysclk,
    input  logic                          reset,
    input  logic [DATA_BITS-1:0]          tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          UART_TX,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_MAX = BW'(CLK_PER_BIT - 1);
    localparam logic [2:0]    DATA_LAST = 3'(DATA_BITS - 1);
    localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

    state_t               r_state, w_nstate;
    logic [BW-1:0]        r_baud;
    logic [2:0]           r_bit;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par;
    logic                 r_tx, w_tx_n;
    logic                 r_rdy;
    logic                 r_ovf;
    logic [CW-1:0]        r_cnt, w_cnt_n;
    logic [AW-1:0]        r_wptr, r_rptr;
    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [DATA_BITS-1:0] w_rdata;
    logic                 w_push, w_pop, w_tick, w_nonempty;

    assign w_push     = tx_valid && r_rdy;
    assign w_tick     = (r_baud == BAUD_MAX);
    assign w_nonempty = (r_cnt != '0);
    assign w_rdata    = r_mem[r_rptr];

    always_comb begin
        w_nstate = r_state;
        w_pop    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_nonempty) begin
                    w_pop    = 1'b1;
                    w_nstate = S_START;
                end
            end
            S_START: if (w_tick) w_nstate = S_DATA;
            S_DATA: begin
                if (w_tick && r_bit == DATA_LAST)
                    w_nstate = (PARITY != 0) ? S_PAR : S_STOP;
            end
            S_PAR: if (w_tick) w_nstate = S_STOP;
            S_STOP: begin
                if (w_tick && r_bit == STOP_LAST) begin
                    if (w_nonempty) begin
                        w_pop    = 1'b1;
                        w_nstate = S_START;
                    end else begin
                        w_nstate = S_IDLE;
                    end
                end
            end
            default: w_nstate = S_IDLE;
        endcase
    end

    // Line value for the next cycle; on a DATA tick the shifter has not moved yet.
    always_comb begin
        w_tx_n = 1'b1;
        case (w_nstate)
            S_START: w_tx_n = 1'b0;
            S_DATA:  w_tx_n = (r_state == S_DATA && w_tick) ? r_shift[1] : r_shift[0];
            S_PAR:   w_tx_n = r_par;
            default: w_tx_n = 1'b1;
        endcase
    end

    always_comb begin
        w_cnt_n = r_cnt;
        case ({w_push, w_pop})
            2'b10:   w_cnt_n = r_cnt + CW'(1);
            2'b01:   w_cnt_n = r_cnt - CW'(1);
            default: w_cnt_n = r_cnt;
        endcase
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_par   <= 1'b0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_nstate;
            r_baud  <= (w_tick || r_state == S_IDLE) ? '0 : r_baud + BW'(1);
            if (w_nstate != r_state)
                r_bit <= '0;
            else if (w_tick)
                r_bit <= r_bit + 3'd1;
            if (w_pop) begin
                r_shift <= w_rdata;
                r_par   <= (PARITY == 1) ? ~^w_rdata : ^w_rdata;
            end else if (r_state == S_DATA && w_tick) begin
                r_shift <= r_shift >> 1;
            end
            r_tx <= w_tx_n;
        end
    end

    // Ready tracks the post-edge count, so a full FIFO refuses even on a pop edge.
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            r_cnt  <= '0;
            r_wptr <= '0;
            r_rptr <= '0;
            r_rdy  <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            r_cnt <= w_cnt_n;
            r_rdy <= (w_cnt_n != FULL_CNT);
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            if (tx_valid && !r_rdy) r_ovf <= 1'b1;
        end
    end

    always_ff @(posedge sysclk) begin
        if (w_push) r_mem[r_wptr] <= tx_data;
    end

    assign tx_ready   = r_rdy;
    assign UART_TX    = r_tx;
    assign busy       = (r_state != S_IDLE);
    assign fifo_count = r_cnt;
    assign overflow   = r_ovf;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench: 8N1/8E1/8O1/5N2 framing, FIFO full behaviour, mid-frame reset.
module tb_uart_tx_fifo;
    logic       sysclk = 1'b0;
    logic       reset  = 1'b1;
    logic [3:0] vld    = '0;
    logic [7:0] dat [4];
    wire  [3:0] txl, bsy, rdy, ovf;
    wire  [2:0] fc0;
    wire  [4:0] fc1, fc2, fc3;
    int n_chk  = 0;
    int n_fail = 0;

    always #5 sysclk = ~sysclk;

    uart_tx_fifo #(.CLK_PER_BIT(4), .FIFO_DEPTH(4)) u0 (
        .sysclk(sysclk), .reset(reset), .tx_data(dat[0]), .tx_valid(vld[0]),
        .tx_ready(rdy[0]), .UART_TX(txl[0]), .busy(bsy[0]), .fifo_count(fc0), .overflow(ovf[0]));
    uart_tx_fifo #(.CLK_PER_BIT(4), .PARITY(2)) u1 (
        .sysclk(sysclk), .reset(reset), .tx_data(dat[1]), .tx_valid(vld[1]),
        .tx_ready(rdy[1]), .UART_TX(txl[1]), .busy(bsy[1]), .fifo_count(fc1), .overflow(ovf[1]));
    uart_tx_fifo #(.CLK_PER_BIT(4), .PARITY(1)) u2 (
        .sysclk(sysclk), .reset(reset), .tx_data(dat[2]), .tx_valid(vld[2]),
        .tx_ready(rdy[2]), .UART_TX(txl[2]), .busy(bsy[2]), .fifo_count(fc2), .overflow(ovf[2]));
    uart_tx_fifo #(.CLK_PER_BIT(4), .DATA_BITS(5), .STOP_BITS(2)) u3 (
        .sysclk(sysclk), .reset(reset), .tx_data(dat[3][4:0]), .tx_valid(vld[3]),
        .tx_ready(rdy[3]), .UART_TX(txl[3]), .busy(bsy[3]), .fifo_count(fc3), .overflow(ovf[3]));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Push one word into instance idx, sample the line mid-bit and time busy.
    task automatic run_frame(input int idx, input logic [7:0] d, input int nb,
                             input logic [15:0] expb, input int elen, input string tag);
        logic [15:0] v = '0;
        int k = 0;
        int nbusy = 0;
        @(negedge sysclk); dat[idx] = d; vld[idx] = 1'b1;
        @(negedge sysclk); vld[idx] = 1'b0;
        for (int c = 1; c < 200; c++) begin
            @(negedge sysclk);
            if (bsy[idx]) nbusy++;
            else if (c > 1) break;
            if (c >= 2 && (c - 2) % 4 == 0 && k < nb) begin
                v = {v[14:0], txl[idx]};
                k++;
            end
        end
        chk({tag, "_bits"}, 32'(v), 32'(expb));
        chk({tag, "_len"}, 32'(nbusy), 32'(elen));
    endtask

    initial begin
        logic [7:0] w [6];
        logic [0:49] smp;
        logic [7:0] b;
        int k, nbusy, tog;
        for (int i = 0; i < 4; i++) dat[i] = '0;
        w[0] = 8'h11; w[1] = 8'h22; w[2] = 8'h33; w[3] = 8'h44; w[4] = 8'h55; w[5] = 8'h66;

        repeat (3) @(negedge sysclk);
        chk("rst_tx",    32'(txl[0]), 32'd1);
        chk("rst_busy",  32'(bsy[0]), 32'd0);
        chk("rst_ready", 32'(rdy[0]), 32'd0);
        chk("rst_count", 32'(fc0),    32'd0);
        chk("rst_ovf",   32'(ovf[0]), 32'd0);
        reset = 1'b0;
        @(negedge sysclk);
        chk("ready_after_rst", 32'(rdy[0]), 32'd1);

        run_frame(0, 8'hA5, 10, 16'b0101001011,   40, "8n1");
        run_frame(1, 8'hA5, 11, 16'b01010010101,  44, "8e1");
        run_frame(2, 8'hA5, 11, 16'b01010010111,  44, "8o1");
        run_frame(3, 8'h13,  8, 16'b01100111,     32, "5n2");
        chk("ovf_clear", 32'(ovf[0]), 32'd0);

        // Six pushes into a depth-4 FIFO, then a push attempted on the first pop edge while full.
        smp = '0; k = 0; nbusy = 0;
        @(negedge sysclk); dat[0] = w[0]; vld[0] = 1'b1;
        for (int c = 0; c < 300; c++) begin
            @(negedge sysclk);
            if (c == 4) begin
                chk("fifo_peak", 32'(fc0), 32'd4);
                chk("full_ready", 32'(rdy[0]), 32'd0);
            end
            if (c == 5) begin
                chk("ovf_set", 32'(ovf[0]), 32'd1);
                chk("full_hold", 32'(fc0), 32'd4);
            end
            if (c == 40) chk("pre_pop_count", 32'(fc0), 32'd4);
            if (c == 41) chk("full_pop_push", 32'(fc0), 32'd3);
            if (c < 5) dat[0] = w[c + 1];
            else if (c == 40) begin vld[0] = 1'b1; dat[0] = 8'h77; end
            else vld[0] = 1'b0;
            if (bsy[0]) nbusy++;
            else if (c > 1) break;
            if (c >= 2 && (c - 2) % 4 == 0 && k < 50) begin
                smp[k] = txl[0];
                k++;
            end
        end
        chk("b2b_len", 32'(nbusy), 32'd200);
        for (int f = 0; f < 5; f++) begin
            for (int i = 0; i < 8; i++) b[i] = smp[f*10 + 1 + i];
            chk($sformatf("b2b_word%0d", f), {22'd0, smp[f*10], smp[f*10+9], b}, {24'd1, w[f]});
        end

        // Reset asserted during data bit 3 of a 0xA5 frame (that bit is 0 on the line).
        @(negedge sysclk); dat[0] = 8'hA5; vld[0] = 1'b1;
        @(negedge sysclk); vld[0] = 1'b0;
        repeat (18) @(negedge sysclk);
        chk("pre_rst_tx", 32'(txl[0]), 32'd0);
        reset = 1'b1;
        #1;
        chk("mid_rst_tx",    32'(txl[0]), 32'd1);
        chk("mid_rst_busy",  32'(bsy[0]), 32'd0);
        chk("mid_rst_count", 32'(fc0),    32'd0);
        chk("mid_rst_ovf",   32'(ovf[0]), 32'd0);
        @(negedge sysclk); reset = 1'b0;
        tog = 0;
        repeat (60) begin
            @(negedge sysclk);
            if (txl[0] !== 1'b1 || bsy[0] !== 1'b0) tog++;
        end
        chk("no_resume", 32'(tog), 32'd0);
        run_frame(0, 8'h3C, 10, 16'b0001111001, 40, "recover");

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
